// File: rtl/color_sensor_emulator.sv
// Behavioural stand-in for a colour-to-frequency sensor: emits a square wave whose half-period
// comes from a per-filter table scaled by the reader's scale select. Define SENSOR_EMU_JITTER_EN for 0/+1 cycle jitter.
module color_sensor_emulator #(
    parameter int HP_W          = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int HP_RED_RST    = 1000,
    parameter int HP_BLUE_RST   = 1200,
    parameter int HP_CLEAR_RST  = 400,
    parameter int HP_GREEN_RST  = 1500
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      scale,
    input  logic [1:0]      filter,
    input  logic            wr_en,
    input  logic [1:0]      wr_sel,
    input  logic [HP_W-1:0] wr_data,
    output logic            sensor_freq,
    output logic            active,
    output logic [15:0]     rise_count
);

    localparam int EFF_W = HP_W + 6;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        OFF,
        SETTLE,
        RUN
    } state_t;

    function automatic logic [5:0] scale_mult(input logic [1:0] s);
        case (s)
            2'b11:   return 6'd1;
            2'b10:   return 6'd5;
            2'b01:   return 6'd50;
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t             state;
    logic [HP_W-1:0]    hp_tbl [4];
    logic [1:0]         scale_q;
    logic [1:0]         filter_q;
    logic [SET_W-1:0]   settle_cnt;
    logic [EFF_W-1:0]   cnt;
    logic [EFF_W-1:0]   hp_lat;
    logic [EFF_W-1:0]   hp_last;
    logic [EFF_W-1:0]   eff_hp;
    logic [EFF_W-1:0]   lat_next;
    logic               chg;
    logic               at_boundary;

    // Product of a HP_W table entry and a 6-bit multiplier never exceeds EFF_W bits.
    assign eff_hp      = EFF_W'(hp_tbl[filter]) * EFF_W'(scale_mult(scale));
    assign chg         = (scale != scale_q) || (filter != filter_q);
    assign hp_last     = hp_lat - EFF_W'(1);
    assign at_boundary = (hp_lat != '0) && (cnt == hp_last);

`ifdef SENSOR_EMU_JITTER_EN
    logic [7:0] lfsr;
    logic       toggle;

    assign toggle   = (state == RUN) && (scale != 2'b00) && !chg && at_boundary;
    // Dark channels must stay exactly zero so they never start toggling.
    assign lat_next = (eff_hp == '0) ? eff_hp : eff_hp + EFF_W'(lfsr[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else if (toggle) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end
`else
    assign lat_next = eff_hp;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_tbl[0] <= HP_W'(HP_RED_RST);
            hp_tbl[1] <= HP_W'(HP_BLUE_RST);
            hp_tbl[2] <= HP_W'(HP_CLEAR_RST);
            hp_tbl[3] <= HP_W'(HP_GREEN_RST);
        end else if (wr_en) begin
            hp_tbl[wr_sel] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= OFF;
            scale_q     <= 2'b00;
            filter_q    <= 2'b00;
            settle_cnt  <= '0;
            cnt         <= '0;
            hp_lat      <= '0;
            sensor_freq <= 1'b0;
            active      <= 1'b0;
            rise_count  <= '0;
        end else begin
            scale_q  <= scale;
            filter_q <= filter;
            case (state)
                OFF: begin
                    sensor_freq <= 1'b0;
                    active      <= 1'b0;
                    if (scale != 2'b00) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    sensor_freq <= 1'b0;
                    active      <= 1'b0;
                    if (scale == 2'b00) begin
                        state <= OFF;
                    end else if (chg) begin
                        settle_cnt <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state      <= RUN;
                        active     <= 1'b1;
                        cnt        <= '0;
                        rise_count <= '0;
                        hp_lat     <= lat_next;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                RUN: begin
                    if (scale == 2'b00) begin
                        state       <= OFF;
                        sensor_freq <= 1'b0;
                        active      <= 1'b0;
                    end else if (chg) begin
                        state       <= SETTLE;
                        settle_cnt  <= '0;
                        sensor_freq <= 1'b0;
                        active      <= 1'b0;
                    end else if (hp_lat == '0) begin
                        // Dark channel: keep polling the table so a new value starts promptly.
                        hp_lat <= lat_next;
                    end else if (at_boundary) begin
                        sensor_freq <= ~sensor_freq;
                        cnt         <= '0;
                        hp_lat      <= lat_next;
                        if (!sensor_freq) begin
                            rise_count <= sat_inc16(rise_count);
                        end
                    end else begin
                        cnt <= cnt + EFF_W'(1);
                    end
                end
                default: begin
                    state       <= OFF;
                    sensor_freq <= 1'b0;
                    active      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_color_sensor_emulator.sv
// Scoreboard bench: stimulus queues expected output events (absolute cycle, level, rise count); a negedge monitor matches them.
module tb_color_sensor_emulator;

    localparam int HP_W = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [1:0]      scale = 2'b00;
    logic [1:0]      filter = 2'b00;
    logic            wr_en = 1'b0;
    logic [1:0]      wr_sel = 2'b00;
    logic [HP_W-1:0] wr_data = '0;
    logic            sensor_freq;
    logic            active;
    logic [15:0]     rise_count;

    color_sensor_emulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scale      (scale),
        .filter     (filter),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .sensor_freq(sensor_freq),
        .active     (active),
        .rise_count (rise_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   kind;   // 1 = active edge, 2 = sensor_freq edge
        int   at;
        logic val;
        int   rc;
    } ev_t;

    ev_t  expq[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;
    logic pa = 1'b0;
    logic pf = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ev(input int kind, input int at, input logic val, input int rc);
        expq.push_back('{kind, at, val, rc});
    endtask

    task automatic take_event(input int kind, input logic val);
        ev_t e;
        n_vec++;
        if (expq.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: kind %0d val %0b at cycle %0d, nothing expected", kind, val, cyc);
        end else begin
            e = expq.pop_front();
            if (e.kind != kind || e.at != cyc || e.val !== val || (kind == 2 && e.rc != int'(rise_count))) begin
                n_err++;
                $display("FAIL event: got kind %0d val %0b cycle %0d rc %0d, expected kind %0d val %0b cycle %0d rc %0d",
                         kind, val, cyc, rise_count, e.kind, e.val, e.at, e.rc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (active !== pa) take_event(1, active);
            if (sensor_freq !== pf) take_event(2, sensor_freq);
            pa <= active;
            pf <= sensor_freq;
        end
    end

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_sel(input logic [1:0] s, input logic [1:0] f);
        scale  = s;
        filter = f;
    endtask

    task automatic wr(input logic [1:0] sel, input int d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_data = HP_W'(d);
    endtask

    initial begin
        repeat (25000) @(posedge clk);
        $display("FAIL watchdog: bench still running at cycle %0d, expected end by 17520", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst_n = 1'b0;
        step_to(2);
        mon_en = 1'b1;
        check("reset_freq", int'(sensor_freq), 0);
        check("reset_active", int'(active), 0);
        check("reset_rise_count", int'(rise_count), 0);
        step_to(5);
        rst_n = 1'b1;

        // Red x1: 64-cycle settle, then 1000-cycle half-periods.
        step_to(10);
        set_sel(2'b11, 2'b00);
        ev(1, 75, 1'b1, 0);
        ev(2, 1075, 1'b1, 1); ev(2, 2075, 1'b0, 1);
        ev(2, 3075, 1'b1, 2); ev(2, 4075, 1'b0, 2);
        ev(2, 5075, 1'b1, 3); ev(2, 6075, 1'b0, 3);
        step_to(6080);
        check("rise_count_3_periods", int'(rise_count), 3);
        check("active_in_run", int'(active), 1);

        // Mid-half-period write to red: current 1000 completes, then 10-cycle halves.
        step_to(6575);
        wr(2'b00, 10);
        step_to(6576);
        wr_en = 1'b0;
        ev(2, 7075, 1'b1, 4); ev(2, 7085, 1'b0, 4);
        ev(2, 7095, 1'b1, 5); ev(2, 7105, 1'b0, 5);
        ev(2, 7115, 1'b1, 6); ev(2, 7125, 1'b0, 6);

        // Blue x5 -> 6000-cycle half-period.
        step_to(7130);
        set_sel(2'b10, 2'b01);
        ev(1, 7131, 1'b0, 0);
        ev(1, 7195, 1'b1, 0);
        ev(2, 13195, 1'b1, 1);

        // Scale to x50 while high: output forced low, re-settle.
        step_to(13200);
        set_sel(2'b01, 2'b01);
        ev(1, 13201, 1'b0, 0);
        ev(2, 13201, 1'b0, 1);
        ev(1, 13265, 1'b1, 0);

        // Filter change plus table write in the same cycle: clear = 3 x50 = 150.
        step_to(13300);
        set_sel(2'b01, 2'b10);
        wr(2'b10, 3);
        step_to(13301);
        wr_en = 1'b0;
        ev(1, 13301, 1'b0, 0);
        ev(1, 13365, 1'b1, 0);
        ev(2, 13515, 1'b1, 1); ev(2, 13665, 1'b0, 1);
        ev(2, 13815, 1'b1, 2); ev(2, 13965, 1'b0, 2);

        // Dark green channel, then wake it with half-period 5.
        step_to(13970);
        set_sel(2'b11, 2'b11);
        wr(2'b11, 0);
        step_to(13971);
        wr_en = 1'b0;
        ev(1, 13971, 1'b0, 0);
        ev(1, 14035, 1'b1, 0);
        step_to(14100);
        check("dark_active", int'(active), 1);
        check("dark_freq", int'(sensor_freq), 0);
        check("dark_rise_count", int'(rise_count), 0);
        wr(2'b11, 5);
        step_to(14101);
        wr_en = 1'b0;
        ev(2, 14107, 1'b1, 1); ev(2, 14112, 1'b0, 1);
        ev(2, 14117, 1'b1, 2); ev(2, 14122, 1'b0, 2);

        // Filter churn faster than the settle time keeps active low.
        step_to(14125);
        set_sel(2'b11, 2'b00);
        ev(1, 14126, 1'b0, 0);
        step_to(14155); filter = 2'b01;
        step_to(14185); filter = 2'b10;
        step_to(14215); filter = 2'b00;
        step_to(14230); scale = 2'b00;
        step_to(14232);
        check("churn_active", int'(active), 0);
        check("churn_freq", int'(sensor_freq), 0);

        // Scale 00 while high in RUN drops to OFF on the next edge.
        step_to(14240);
        set_sel(2'b11, 2'b00);
        ev(1, 14305, 1'b1, 0);
        ev(2, 14315, 1'b1, 1);
        step_to(14317);
        set_sel(2'b00, 2'b01);
        ev(1, 14318, 1'b0, 0);
        ev(2, 14318, 1'b0, 1);

        // Async reset mid-high-phase, then defaults restored (red 1000 again).
        step_to(14330);
        set_sel(2'b11, 2'b00);
        ev(1, 14395, 1'b1, 0);
        ev(2, 14405, 1'b1, 1); ev(2, 14415, 1'b0, 1);
        ev(2, 14425, 1'b1, 2);
        step_to(14430);
        ev(1, 14430, 1'b0, 0);
        ev(2, 14430, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("async_reset_freq", int'(sensor_freq), 0);
        check("async_reset_rise_count", int'(rise_count), 0);
        step_to(14433);
        rst_n = 1'b1;
        ev(1, 14498, 1'b1, 0);
        ev(2, 15498, 1'b1, 1); ev(2, 16498, 1'b0, 1);
        ev(2, 17498, 1'b1, 2);
        step_to(17500);
        set_sel(2'b00, 2'b00);
        ev(1, 17501, 1'b0, 0);
        ev(2, 17501, 1'b0, 2);

        step_to(17520);
        check("events_outstanding", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/color_sensor_emulator.md
Name: color_sensor_emulator

Overview:
- Behavioural responder for the colour-sensor interface. Consumes the scale/filter selects driven by the sensor reader and produces a square wave on `sensor_freq`.
- The wave's frequency is set by a per-filter programmable half-period, scaled like the real part.
- Used on-board in place of the physical sensor for hardware-in-loop bring-up, and in simulation as the reader's stimulus source.

Parameters:
- HP_W, 16, width of each programmed half-period value (clk cycles).
- SETTLE_CYCLES, 64, cycles `sensor_freq` is held low after any filter/scale change.
- HP_RED_RST, 1000, reset half-period for filter 00 (red).
- HP_BLUE_RST, 1200, reset half-period for filter 01 (blue).
- HP_CLEAR_RST, 400, reset half-period for filter 10 (clear).
- HP_GREEN_RST, 1500, reset half-period for filter 11 (green).

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- scale, in, 2, output scaling select from the reader.
- filter, in, 2, photodiode select from the reader: 00 red, 01 blue, 11 green, 10 clear.
- wr_en, in, 1, write strobe for the half-period table.
- wr_sel, in, 2, table entry written; same encoding as `filter`.
- wr_data, in, HP_W, half-period value written.
- sensor_freq, out, 1, emulated sensor output square wave.
- active, out, 1, high while in RUN.
- rise_count, out, 16, rising edges of `sensor_freq` since the last RUN entry; saturates at 0xFFFF.

Behaviour:
- Reset (async, rst_n=0):
  - `sensor_freq`=0, `active`=0, `rise_count`=0.
  - State=OFF.
  - Table loaded with the *_RST parameters.
  - Counters cleared.
  - `scale`/`filter` history registers loaded with 00.
- Scale multiplier:
  - 11 → x1; 10 → x5; 01 → x50; 00 → power-down.
  - eff_hp = table[filter] * mult, computed at width HP_W+6 with no truncation.
- Change detection:
  - `scale` and `filter` are registered every cycle.
  - Any difference between the registered copy and the current input is a "change event".
- States:
  - OFF: `sensor_freq`=0, `active`=0. Leave when scale≠00 → SETTLE, with settle counter=0.
  - SETTLE: `sensor_freq`=0. Counts SETTLE_CYCLES cycles, then → RUN. A change event restarts the count at 0. scale=00 → OFF.
  - RUN:
    - `active`=1. On entry: cnt=0, `rise_count`=0, `sensor_freq`=0, eff_hp latched.
    - Each cycle cnt++. When cnt==latched_eff_hp-1: toggle `sensor_freq`, cnt=0, re-latch eff_hp.
    - Period is 2*eff_hp cycles; first rising edge occurs eff_hp cycles after RUN entry.
    - A change event → SETTLE (output forced 0 in the same cycle). scale=00 → OFF.
- Half-period 0:
  - Channel reads "dark": in RUN the output stays 0, cnt holds, `active`=1, `rise_count` stays 0.
  - A later write of a non-zero value to that channel takes effect the next cycle (latch refreshes while the latched value is 0).
- Table write:
  - When wr_en=1, table[wr_sel]=wr_data at the clock edge.
  - A write to the currently selected channel during RUN takes effect at the next toggle (latched at the boundary), never mid-half-period.
- Simultaneous events:
  - Write plus change event in the same cycle: the write commits, and the subsequent RUN entry uses the new value.
  - scale→00 takes priority over all other transitions.
- `rise_count` increments on each 0→1 toggle, saturating at 0xFFFF (no wrap).
- Reset asserted mid-RUN: output drops to 0 asynchronously and the table reverts to the defaults.

Optional Feature:
- Macro: SENSOR_EMU_JITTER_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 0xA5 on reset) advances once per toggle.
  - Its LSB is added to the latched eff_hp, giving 0 or +1 cycle per half-period to mimic sensor jitter.
  - Dark (0) channels are unaffected.
- Not defined: no LFSR; half-periods are exact.

Test Plan:
1. Reset with defaults, filter=00, scale=11 → `sensor_freq` low for 64 cycles (SETTLE). `active` rises at cycle 65; first rise 1000 cycles later; period 2000 cycles; `rise_count`=3 after 3 full periods.
2. scale=10, filter=01 → eff_hp=6000, period 12000 cycles. Switch scale to 01 → output forced low, 64-cycle settle, then period 120000.
3. Mid-RUN on red, write wr_sel=00, wr_data=10 → current half-period completes at 1000; following half-periods are 10 cycles (period 20).
4. Write wr_sel=11, wr_data=0, select filter=11 → `active`=1, `sensor_freq` stays 0, `rise_count`=0. Write 5 → toggling with period 10 starting the next cycle.
5. Filter change every 30 cycles (less than SETTLE_CYCLES) → `active` never asserts and the output stays 0. scale=00 at any point → OFF within one cycle.
6. Assert rst_n=0 mid-half-period → `sensor_freq`=0 immediately. After release, table reads defaults (red period 2000 again). With SENSOR_EMU_JITTER_EN defined, each measured half-period on red is 1000 or 1001.
